// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ word sources.
// A grant is held from word capture until the transmitter reports the end of the whole frame.
module uart_tx_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int W_OUT   = 24,
    parameter  int CNT_W   = 16,
    localparam int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*W_OUT-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_en,
    output logic                     m_valid,
    output logic [W_OUT-1:0]         m_data,
    input  logic                     m_ready,
    output logic [GNT_W-1:0]         grant_id,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       done,
    output logic [CNT_W-1:0]         frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               m_valid_q, m_valid_d;
    logic [W_OUT-1:0]   m_data_q, m_data_d;
    logic [GNT_W-1:0]   grant_id_q, grant_id_d;
    logic [GNT_W-1:0]   last_q, last_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [NUM_REQ-1:0] elig;
    logic               win_found;
    logic [GNT_W-1:0]   win_idx;
    int                 idx;

    assign elig = req_valid & req_en;

    // Search from the largest offset down so the candidate closest after last_q wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_q) + off) % NUM_REQ;
            if (elig[idx]) begin
                win_found = 1'b1;
                win_idx   = GNT_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rstn && (state_q == IDLE) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        grant_id_d  = grant_id_q;
        last_d      = last_q;
        done_d      = '0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    m_data_d   = req_data[int'(win_idx)*W_OUT +: W_OUT];
                    m_valid_d  = 1'b1;
                    grant_id_d = win_idx;
                    last_d     = win_idx;
                    state_d    = SEND;
                end
            end
            SEND: begin
                m_valid_d = 1'b1;
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            // m_ready returning high marks the transmitter's end of frame.
            DRAIN: begin
                if (m_ready) begin
                    done_d[grant_id_q] = 1'b1;
                    frame_cnt_d        = frame_cnt_q + 1'b1;
                    state_d            = IDLE;
                end
            end
            default: begin
                m_valid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        busy_d = (state_d == SEND) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            grant_id_q  <= '0;
            last_q      <= GNT_W'(NUM_REQ - 1);
            busy_q      <= 1'b0;
            done_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            grant_id_q  <= grant_id_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler; a second CNT_W=4 instance on the same stimulus
// exercises frame counter wrap.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [95:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  req_en;
    logic        m_valid;
    logic [23:0] m_data;
    logic        m_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic [3:0]  done;
    logic [15:0] frame_cnt;

    logic [3:0]  req_ready_s;
    logic        m_valid_s;
    logic [23:0] m_data_s;
    logic [1:0]  grant_id_s;
    logic        busy_s;
    logic [3:0]  done_s;
    logic [3:0]  frame_cnt_s;

    int          assert_count;
    int          fail_count;
    int          exp_cnt;
    int          onehot_viol;
    logic [3:0]  seen_ready;
    logic [23:0] slot_val [4];
    logic [23:0] held_data;

    uart_tx_scheduler #(.NUM_REQ(4), .W_OUT(24), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_en(req_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .grant_id(grant_id), .busy(busy), .done(done),
        .frame_cnt(frame_cnt)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .W_OUT(24), .CNT_W(4)) dut_small (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready_s), .req_en(req_en), .m_valid(m_valid_s), .m_data(m_data_s),
        .m_ready(m_ready), .grant_id(grant_id_s), .busy(busy_s), .done(done_s),
        .frame_cnt(frame_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sticky record of every requester that saw req_ready, plus one-hot violations.
    always @(negedge clk) begin
        #3;
        seen_ready = seen_ready | req_ready;
        if ($countones(req_ready) > 1) onehot_viol++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadData();
        req_data = {slot_val[3], slot_val[2], slot_val[1], slot_val[0]};
    endtask

    task automatic applyReset();
        rstn      = 1'b0;
        req_valid = 4'b0000;
        req_en    = 4'b1111;
        m_ready   = 1'b1;
        exp_cnt   = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_m_valid",   32'(m_valid),     32'h0);
        checkOutput("rst_m_data",    32'(m_data),      32'h0);
        checkOutput("rst_req_ready", 32'(req_ready),   32'h0);
        checkOutput("rst_grant_id",  32'(grant_id),    32'h0);
        checkOutput("rst_busy",      32'(busy),        32'h0);
        checkOutput("rst_done",      32'(done),        32'h0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt),   32'h0);
        checkOutput("rst_cnt_small", 32'(frame_cnt_s), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Called in an IDLE cycle where requester g must win; runs one frame with a
    // short end-of-frame wait and applies the next request pattern before completion.
    task automatic applyStimulus(input int g, input logic [3:0] next_valid,
                                 input logic [3:0] next_en);
        logic [3:0] g_hot;
        g_hot = 4'b0001 << g;
        #1;
        checkOutput("grant_ready", 32'(req_ready), 32'(g_hot));
        @(negedge clk);
        #1;
        checkOutput("send_m_valid",   32'(m_valid),   32'h1);
        checkOutput("send_m_data",    32'(m_data),    32'(slot_val[g]));
        checkOutput("send_grant_id",  32'(grant_id),  32'(g));
        checkOutput("send_busy",      32'(busy),      32'h1);
        checkOutput("send_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        checkOutput("drain_m_valid", 32'(m_valid), 32'h0);
        checkOutput("drain_busy",    32'(busy),    32'h1);
        checkOutput("drain_done",    32'(done),    32'h0);
        repeat (2) @(negedge clk);
        m_ready   = 1'b1;
        req_valid = next_valid;
        req_en    = next_en;
        @(negedge clk);
        #1;
        exp_cnt++;
        checkOutput("done_pulse",    32'(done),        32'(g_hot));
        checkOutput("frame_cnt",     32'(frame_cnt),   32'(exp_cnt % 65536));
        checkOutput("cnt_small",     32'(frame_cnt_s), 32'(exp_cnt % 16));
        checkOutput("end_busy",      32'(busy),        32'h0);
        checkOutput("end_grant_id",  32'(grant_id),    32'(g));
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        onehot_viol  = 0;
        seen_ready   = 4'b0000;
        slot_val[0]  = 24'h111111;
        slot_val[1]  = 24'h222222;
        slot_val[2]  = 24'h333333;
        slot_val[3]  = 24'h444444;
        loadData();
        applyReset();

        $display("[TB] T1 single request");
        slot_val[0] = 24'hA1B2C3;
        loadData();
        req_valid = 4'b0001;
        applyStimulus(0, 4'b0000, 4'b1111);
        @(negedge clk);
        #1;
        checkOutput("t1_done_clear", 32'(done),      32'h0);
        checkOutput("t1_no_grant",   32'(req_ready), 32'h0);
        checkOutput("t1_idle_valid", 32'(m_valid),   32'h0);

        $display("[TB] T2 all requesters round robin");
        applyReset();
        slot_val[0] = 24'h111111;
        loadData();
        @(negedge clk);
        req_valid = 4'b1111;
        req_en    = 4'b1111;
        for (int k = 0; k < 7; k++) applyStimulus(k % 4, 4'b1111, 4'b1111);
        seen_ready = 4'b0000;
        applyStimulus(3, 4'b1111, 4'b1010);

        $display("[TB] T3 enable mask 1010");
        applyStimulus(1, 4'b1111, 4'b1010);
        applyStimulus(3, 4'b1111, 4'b1010);
        applyStimulus(1, 4'b1111, 4'b1010);
        applyStimulus(3, 4'b0000, 4'b1111);
        checkOutput("t3_masked_ready", 32'(seen_ready & 4'b0101), 32'h0);

        $display("[TB] T4 transmitter stall in SEND");
        @(negedge clk);
        slot_val[2] = 24'hC0FFEE;
        loadData();
        req_valid = 4'b0100;
        m_ready   = 1'b0;
        #1;
        checkOutput("t4_grant_ready", 32'(req_ready), 32'h4);
        held_data = slot_val[2];
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 4'b0000;
                slot_val[2] = 24'h000000;
                loadData();
            end
            #1;
            checkOutput("t4_hold_valid", 32'(m_valid), 32'h1);
            checkOutput("t4_hold_data",  32'(m_data),  32'(held_data));
        end
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t4_accept_valid", 32'(m_valid), 32'h0);
        checkOutput("t4_accept_busy",  32'(busy),    32'h1);
        @(negedge clk);
        #1;
        exp_cnt++;
        checkOutput("t4_done",      32'(done),      32'h4);
        checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        $display("[TB] T5 reset during DRAIN");
        @(negedge clk);
        slot_val[2] = 24'h333333;
        slot_val[3] = 24'h777777;
        loadData();
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        checkOutput("t5_drain_busy",  32'(busy),     32'h1);
        checkOutput("t5_drain_grant", 32'(grant_id), 32'h3);
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = 4'b1111;
        #1;
        checkOutput("t5_rst_m_valid",   32'(m_valid),     32'h0);
        checkOutput("t5_rst_m_data",    32'(m_data),      32'h0);
        checkOutput("t5_rst_req_ready", 32'(req_ready),   32'h0);
        checkOutput("t5_rst_grant_id",  32'(grant_id),    32'h0);
        checkOutput("t5_rst_busy",      32'(busy),        32'h0);
        checkOutput("t5_rst_frame_cnt", 32'(frame_cnt),   32'h0);
        checkOutput("t5_rst_cnt_small", 32'(frame_cnt_s), 32'h0);
        exp_cnt = 0;
        @(negedge clk);
        rstn    = 1'b1;
        m_ready = 1'b1;
        req_en  = 4'b1111;
        applyStimulus(0, 4'b0001, 4'b1111);

        $display("[TB] T6 narrow counter wrap");
        for (int k = 0; k < 14; k++) applyStimulus(0, 4'b0001, 4'b1111);
        checkOutput("t6_small_allones", 32'(frame_cnt_s), 32'hF);
        applyStimulus(0, 4'b0000, 4'b1111);
        checkOutput("t6_small_wrapped", 32'(frame_cnt_s), 32'h0);
        checkOutput("t6_wide_count",    32'(frame_cnt),   32'd16);

        @(negedge clk);
        checkOutput("onehot_ready", 32'(onehot_viol), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
